// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the fetch / load-store memory port arbiter.
//   - arb_state_t          : arbiter FSM state encoding
//   - XLEN                 : data/address width
//   - STARVE_LIMIT_DEFAULT : default number of consecutive LS grants while IF waits
//   - word_align()         : clears the byte offset of a byte address
package mem_port_arbiter_pkg;

  localparam int XLEN                 = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_t;

  // Memory is word addressed on the port; byte lanes are selected by mem_be.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr
//   Saturating counter of LS grants taken while a fetch was waiting.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     inc_i       : count one more LS grant that bypassed a waiting fetch
//     clr_i       : clear (fetch granted, or no fetch waiting); wins over inc_i
//     starved_o   : counter has reached LIMIT, fetch must win the next tie
module mem_arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic starved_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, increment saturates at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates one shared memory port between instruction fetch (IF) and
//   load/store (LS). LS normally has priority; after STARVE_LIMIT consecutive
//   LS grants with a fetch waiting, the fetch wins the next tie.
//   Ports:
//     clk, reset                               : clock, synchronous active-high reset
//     if_req/if_addr/if_flush                  : fetch request, byte address, redirect
//     if_gnt/if_rvalid/if_rdata                : fetch accept, response pulse, instruction
//     ls_req/ls_we/ls_addr/ls_wdata/ls_be      : load/store request fields
//     ls_gnt/ls_rvalid/ls_rdata                : LS accept, completion pulse, load data
//     mem_req/mem_we/mem_addr/mem_wdata/mem_be : shared memory port (registered)
//     mem_ready/mem_rdata                      : memory completion pulse and read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [3:0]      ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  arb_state_t      state_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [3:0]      mem_be_q;
  logic            if_rvalid_q;
  logic [XLEN-1:0] if_rdata_q;
  logic            ls_rvalid_q;
  logic [XLEN-1:0] ls_rdata_q;
  logic            drop_q;

  logic            if_ok_s;
  logic            starved_s;
  logic            if_gnt_s;
  logic            ls_gnt_s;
  logic            starve_inc_s;
  logic            starve_clr_s;

  // A flushed fetch address is stale, so it may never be granted.
  assign if_ok_s = if_req && !if_flush;

  // Combinational grant, only in IDLE and never during reset.
  always_comb begin
    if_gnt_s = 1'b0;
    ls_gnt_s = 1'b0;
    if (!reset && (state_q == IDLE)) begin
      if (ls_req && !(starved_s && if_ok_s)) begin
        ls_gnt_s = 1'b1;
      end else if (if_ok_s) begin
        if_gnt_s = 1'b1;
      end else begin
        ls_gnt_s = 1'b0;
      end
    end else begin
      if_gnt_s = 1'b0;
    end
  end

  assign starve_inc_s = ls_gnt_s && if_ok_s;
  assign starve_clr_s = if_gnt_s || ((state_q == IDLE) && !if_req);

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (starve_inc_s),
    .clr_i     (starve_clr_s),
    .starved_o (starved_s)
  );

  // Arbiter FSM with registered memory-port fields and responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      mem_be_q    <= 4'h0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= {XLEN{1'b0}};
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= {XLEN{1'b0}};
      drop_q      <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (ls_gnt_s) begin
            state_q     <= BUSY_LS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ls_we;
            mem_addr_q  <= word_align(ls_addr);
            mem_wdata_q <= ls_wdata;
            mem_be_q    <= ls_be;
          end else if (if_gnt_s) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= word_align(if_addr);
            mem_wdata_q <= {XLEN{1'b0}};
            mem_be_q    <= 4'hF;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            drop_q    <= 1'b0;
            // A flush in the completion cycle also kills the response.
            if (!drop_q && !if_flush) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end else begin
              if_rvalid_q <= 1'b0;
            end
          end else if (if_flush) begin
            drop_q <= 1'b1;
          end else begin
            drop_q <= drop_q;
          end
        end
        BUSY_LS: begin
          if (mem_ready) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            ls_rvalid_q <= 1'b1;
            ls_rdata_q  <= mem_we_q ? {XLEN{1'b0}} : mem_rdata;
          end else begin
            state_q <= BUSY_LS;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          drop_q    <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_s;
  assign ls_gnt    = ls_gnt_s;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
//   rising edge; checks happen 2 time units after it, once both the registered
//   outputs and the combinational grants have settled.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be, mem_be;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;

    // Reset state, with a fetch request present that must not be granted.
    tick(); tick(); settle();
    chk("rst_if_gnt",   32'(if_gnt), 32'h0);
    chk("rst_mem_req",  32'(mem_req), 32'h0);
    chk("rst_rvalid",   32'({if_rvalid, ls_rvalid}), 32'h0);
    chk("rst_rdata",    if_rdata | ls_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_state",    32'(dut.state_q), 32'(IDLE));
    chk("rst_starve",   32'(dut.u_starve.cnt_q), 32'h0);
    tick();
    reset = 1'b0; if_req = 1'b0;

    // IF only: grant cycle 0, mem_ready in cycle 2, if_rvalid in cycle 3.
    if_req = 1'b1; if_addr = 32'h0000_0010; settle();
    chk("if0_gnt", 32'({if_gnt, ls_gnt}), 32'h2);
    tick(); if_req = 1'b0; settle();
    chk("if1_mem_req", 32'(mem_req), 32'h1);
    chk("if1_addr",    mem_addr, 32'h0000_0010);
    chk("if1_we_be",   32'({mem_we, mem_be}), 32'h0F);
    chk("if1_gnt",     32'(if_gnt), 32'h0);
    tick(); mem_ready = 1'b1; mem_rdata = 32'h0050_0093; settle();
    chk("if2_mem_req", 32'(mem_req), 32'h1);
    chk("if2_rvalid",  32'(if_rvalid), 32'h0);
    tick(); mem_ready = 1'b0; mem_rdata = 32'h0; settle();
    chk("if3_rvalid",  32'(if_rvalid), 32'h1);
    chk("if3_rdata",   if_rdata, 32'h0050_0093);
    chk("if3_mem_req", 32'(mem_req), 32'h0);
    tick(); settle();
    chk("if4_rvalid",  32'(if_rvalid), 32'h0);
    chk("if4_hold",    if_rdata, 32'h0050_0093);

    // Simultaneous requests: LS first, IF granted in the LS rvalid cycle.
    if_req = 1'b1; if_addr = 32'h0000_0020;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0104; ls_be = 4'hF; settle();
    chk("sim_ls_first", 32'({if_gnt, ls_gnt}), 32'h1);
    tick(); ls_req = 1'b0; settle();
    chk("sim_ls_addr",  mem_addr, 32'h0000_0104);
    chk("sim_busy_gnt", 32'(if_gnt), 32'h0);
    chk("sim_starve1",  32'(dut.u_starve.cnt_q), 32'h1);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick(); mem_ready = 1'b0; settle();
    chk("sim_ls_rvalid", 32'(ls_rvalid), 32'h1);
    chk("sim_ls_rdata",  ls_rdata, 32'hCAFE_F00D);
    chk("sim_if_gnt",    32'(if_gnt), 32'h1);
    tick(); if_req = 1'b0; settle();
    chk("sim_if_addr", mem_addr, 32'h0000_0020);
    chk("sim_starve0", 32'(dut.u_starve.cnt_q), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    tick(); mem_ready = 1'b0; settle();
    chk("sim_if_rdata", if_rdata, 32'h1111_1111);

    // Starvation: four LS grants, then the waiting fetch wins.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0080;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("stv_ls_gnt", 32'({if_gnt, ls_gnt}), 32'h1);
      tick(); mem_ready = 1'b1; mem_rdata = 32'(k);
      tick(); mem_ready = 1'b0;
    end
    settle();
    chk("stv_cnt4",   32'(dut.u_starve.cnt_q), 32'h4);
    chk("stv_if_gnt", 32'({if_gnt, ls_gnt}), 32'h2);
    tick(); if_req = 1'b0; settle();
    chk("stv_cnt0",    32'(dut.u_starve.cnt_q), 32'h0);
    chk("stv_if_addr", mem_addr, 32'h0000_0040);
    mem_ready = 1'b1; mem_rdata = 32'h2222_2222;
    tick(); mem_ready = 1'b0; settle();
    chk("stv_if_rvalid", 32'(if_rvalid), 32'h1);
    chk("stv_ls_again",  32'(ls_gnt), 32'h1);
    tick(); ls_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h3333_3333;
    tick(); mem_ready = 1'b0; settle();
    chk("stv_ls_rdata", ls_rdata, 32'h3333_3333);

    // Flush during BUSY_IF: transaction completes, response dropped.
    if_req = 1'b1; if_addr = 32'h0000_0030; settle();
    chk("fl_gnt", 32'(if_gnt), 32'h1);
    tick(); if_req = 1'b0; if_flush = 1'b1; settle();
    chk("fl_mem_req", 32'(mem_req), 32'h1);
    tick(); if_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick(); mem_ready = 1'b0; settle();
    chk("fl_no_rvalid", 32'(if_rvalid), 32'h0);
    chk("fl_rdata_hold", if_rdata, 32'h2222_2222);
    chk("fl_mem_req0", 32'(mem_req), 32'h0);
    if_req = 1'b1; if_addr = 32'h0000_0200; if_flush = 1'b1; settle();
    chk("fl_gnt_block", 32'(if_gnt), 32'h0);
    if_flush = 1'b0; settle();
    chk("fl_gnt_200", 32'(if_gnt), 32'h1);
    tick(); if_req = 1'b0; settle();
    chk("fl_addr_200", mem_addr, 32'h0000_0200);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0213;
    tick(); mem_ready = 1'b0; settle();
    chk("fl_rvalid_200", 32'(if_rvalid), 32'h1);
    chk("fl_rdata_200",  if_rdata, 32'h0000_0213);

    // Store: aligned address, byte enables, zero completion data.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0103; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b1000;
    settle();
    chk("st_gnt", 32'(ls_gnt), 32'h1);
    tick(); ls_req = 1'b0; settle();
    chk("st_addr",  mem_addr, 32'h0000_0100);
    chk("st_we_be", 32'({mem_we, mem_be}), 32'h18);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    tick(); mem_ready = 1'b0; settle();
    chk("st_rvalid", 32'(ls_rvalid), 32'h1);
    chk("st_rdata",  ls_rdata, 32'h0);

    // Reset in BUSY_LS: transaction abandoned, late mem_ready ignored.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0300; settle();
    chk("rb_gnt", 32'(ls_gnt), 32'h1);
    tick(); ls_req = 1'b0; settle();
    chk("rb_mem_req", 32'(mem_req), 32'h1);
    reset = 1'b1;
    tick(); reset = 1'b0; settle();
    chk("rb_state",   32'(dut.state_q), 32'(IDLE));
    chk("rb_mem_req0", 32'(mem_req), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    tick(); mem_ready = 1'b0; settle();
    chk("rb_no_rvalid", 32'(ls_rvalid), 32'h0);
    chk("rb_idle_req",  32'(mem_req), 32'h0);
    tick(); settle();
    chk("rb_no_rvalid2", 32'(ls_rvalid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
